// File: rtl/vdp_dotclk_gen.sv
// Dot-clock and timing-enable generator with slot-aligned start and drain-before-switch reconfiguration.
// Optional macro VDP_DOTCLK_RESYNC_CNT_EN builds the RESYNC_CNT reconfiguration counter.
module vdp_dotclk_gen #(
  parameter int unsigned NUM_SRC       = 3,
  parameter int unsigned DIV_W         = 3,
  parameter int unsigned SYNC_MEMORY   = 1,
  parameter int unsigned MEM_PERIOD    = 4,
  parameter int unsigned DRAIN_TIMEOUT = 64
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [NUM_SRC-1:0]         SRC_EN,
  input  logic [$clog2(NUM_SRC)-1:0] SRC_SEL,
  input  logic [DIV_W-1:0]           DIV,
  input  logic                       RAM_REQ,
  output logic                       MEM_REQ,
  output logic                       CLK_MASTER_EN,
  output logic                       DCLK_EN,
  output logic                       TG_EN,
  output logic [DIV_W-1:0]           DCLK_PHASE,
  output logic                       BUSY,
  output logic [7:0]                 RESYNC_CNT
);

  localparam int unsigned SEL_W = $clog2(NUM_SRC);
  localparam int unsigned TO_W  = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [SEL_W-1:0]  active_sel;
  logic [DIV_W-1:0]  active_div;
  logic [SEL_W-1:0]  prev_sel;
  logic [DIV_W-1:0]  prev_div;
  logic [DIV_W-1:0]  cnt;
  logic [TO_W-1:0]   to_cnt;

  logic              req_change_c;
  logic [SEL_W-1:0]  req_sel_c;
  logic              dot_c;
  logic              to_done_c;
  logic              drain_exit_c;

  // Out-of-range source requests fall back to the highest source
  always_comb begin
    req_sel_c = SRC_SEL;
    if (32'(SRC_SEL) >= NUM_SRC) req_sel_c = SEL_W'(NUM_SRC - 1);
  end

  assign CLK_MASTER_EN = SRC_EN[active_sel];
  assign req_change_c  = (SRC_SEL != prev_sel) || (DIV != prev_div);
  assign dot_c         = CLK_MASTER_EN && (cnt == '0);
  assign to_done_c     = (to_cnt == TO_W'(DRAIN_TIMEOUT - 1));
  assign drain_exit_c  = (state == ST_DRAIN) && (dot_c || to_done_c);
  assign DCLK_PHASE    = cnt;

  // Slot strobe source: pass-through from the RAM controller or a local slot counter
  if (SYNC_MEMORY != 0) begin : g_ext_mem
    assign MEM_REQ = RAM_REQ;
  end else begin : g_int_mem
    localparam int unsigned SLOT_W = (MEM_PERIOD > 1) ? $clog2(MEM_PERIOD) : 1;
    logic [SLOT_W-1:0] slot;
    logic              unused_ram_req;
    assign unused_ram_req = RAM_REQ;

    always_ff @(posedge CLK) begin
      if (RESET) begin
        slot    <= '0;
        MEM_REQ <= 1'b0;
      end else begin
        MEM_REQ <= SRC_EN[0] && (slot == SLOT_W'(MEM_PERIOD - 1));
        if (SRC_EN[0]) begin
          slot <= (slot == SLOT_W'(MEM_PERIOD - 1)) ? '0 : slot + SLOT_W'(1);
        end
      end
    end
  end

  // Control FSM: the old configuration keeps counting in DRAIN until a dot boundary or timeout
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_SYNC;
      active_sel <= '0;
      active_div <= '0;
      prev_sel   <= SRC_SEL;
      prev_div   <= DIV;
      cnt        <= '0;
      to_cnt     <= '0;
      DCLK_EN    <= 1'b0;
      TG_EN      <= 1'b0;
      BUSY       <= 1'b1;
    end else begin
      prev_sel <= SRC_SEL;
      prev_div <= DIV;
      DCLK_EN  <= 1'b0;
      case (state)
        ST_SYNC: begin
          TG_EN <= 1'b0;
          BUSY  <= 1'b1;
          if (req_change_c) begin
            active_sel <= req_sel_c;
            active_div <= DIV;
          end else if (MEM_REQ) begin
            state <= ST_RUN;
            cnt   <= active_div;
            TG_EN <= 1'b1;
            BUSY  <= 1'b0;
          end
        end
        ST_RUN, ST_DRAIN: begin
          if (CLK_MASTER_EN) begin
            if (cnt == '0) begin
              DCLK_EN <= 1'b1;
              cnt     <= active_div;
            end else begin
              cnt <= cnt - DIV_W'(1);
            end
          end
          if (state == ST_RUN) begin
            if (req_change_c) begin
              state  <= ST_DRAIN;
              BUSY   <= 1'b1;
              to_cnt <= '0;
            end
          end else if (drain_exit_c) begin
            state      <= ST_SYNC;
            TG_EN      <= 1'b0;
            active_sel <= req_sel_c;
            active_div <= DIV;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: state <= ST_SYNC;
      endcase
    end
  end

`ifdef VDP_DOTCLK_RESYNC_CNT_EN
  logic [6:0] resync_num;
  logic       resync_to;

  // Bits 6:0 count completed drains (saturating), bit 7 remembers any timeout exit
  always_ff @(posedge CLK) begin
    if (RESET) begin
      resync_num <= '0;
      resync_to  <= 1'b0;
    end else if (drain_exit_c) begin
      if (resync_num != 7'h7f) resync_num <= resync_num + 7'd1;
      if (to_done_c && !dot_c) resync_to <= 1'b1;
    end
  end

  assign RESYNC_CNT = {resync_to, resync_num};
`else
  assign RESYNC_CNT = 8'h00;
`endif

endmodule

// File: tb/tb_vdp_dotclk_gen.sv
// Bench for vdp_dotclk_gen: directed scenarios plus randomized traffic against an enable-counting reference model.
module tb_vdp_dotclk_gen;

  localparam int NSRC    = 3;
  localparam int TIMEOUT = 64;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [2:0] SRC_EN;
  logic [1:0] SRC_SEL;
  logic [2:0] DIV;
  logic       RAM_REQ;

  logic       a_mem, a_cme, a_dclk, a_tg, a_busy;
  logic [2:0] a_phase;
  logic [7:0] a_rc;
  logic       b_mem_o, b_cme, b_dclk, b_tg, b_busy;
  logic [2:0] b_phase;
  logic [7:0] b_rc;

  vdp_dotclk_gen #(.NUM_SRC(3), .DIV_W(3), .SYNC_MEMORY(1), .MEM_PERIOD(4), .DRAIN_TIMEOUT(64)) dut_a (
    .CLK(CLK), .RESET(RESET), .SRC_EN(SRC_EN), .SRC_SEL(SRC_SEL), .DIV(DIV), .RAM_REQ(RAM_REQ),
    .MEM_REQ(a_mem), .CLK_MASTER_EN(a_cme), .DCLK_EN(a_dclk), .TG_EN(a_tg),
    .DCLK_PHASE(a_phase), .BUSY(a_busy), .RESYNC_CNT(a_rc));

  vdp_dotclk_gen #(.NUM_SRC(3), .DIV_W(3), .SYNC_MEMORY(0), .MEM_PERIOD(4), .DRAIN_TIMEOUT(64)) dut_b (
    .CLK(CLK), .RESET(RESET), .SRC_EN(SRC_EN), .SRC_SEL(SRC_SEL), .DIV(DIV), .RAM_REQ(RAM_REQ),
    .MEM_REQ(b_mem_o), .CLK_MASTER_EN(b_cme), .DCLK_EN(b_dclk), .TG_EN(b_tg),
    .DCLK_PHASE(b_phase), .BUSY(b_busy), .RESYNC_CNT(b_rc));

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0=waiting for slot, 1=running, 2=draining
  int m_mode, m_sel, m_div, m_n, m_phase, m_to, m_rnum;
  int last_sel, last_div, b_n0;
  bit m_dclk, m_tg, m_busy, m_rflag, b_mem;
  int tgl = 0;

  function automatic int clamp_sel(input int s);
    return (s >= NSRC) ? NSRC - 1 : s;
  endfunction

  function automatic logic [7:0] exp_rc();
`ifdef VDP_DOTCLK_RESYNC_CNT_EN
    return {m_rflag, 7'(m_rnum)};
`else
    return 8'h00;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int  s_in, d_in;
    bit  chg, me, dot, tout;
    s_in = int'(SRC_SEL);
    d_in = int'(DIV);
    if (RESET) begin
      m_mode = 0; m_sel = 0; m_div = 0; m_n = 0; m_phase = 0; m_to = 0;
      m_dclk = 0; m_tg = 0; m_busy = 1; m_rnum = 0; m_rflag = 0;
      b_n0 = 0; b_mem = 0;
    end else begin
      chg    = (s_in != last_sel) || (d_in != last_div);
      me     = SRC_EN[m_sel];
      m_dclk = 0;
      if (m_mode == 0) begin
        m_tg = 0; m_busy = 1;
        if (chg) begin
          m_sel = clamp_sel(s_in); m_div = d_in;
        end else if (RAM_REQ) begin
          m_mode = 1; m_n = 0; m_phase = m_div; m_tg = 1; m_busy = 0;
        end
      end else begin
        dot = 0;
        if (me) begin
          m_n++;
          dot     = (m_n % (m_div + 1)) == 0;
          m_phase = m_div - (m_n % (m_div + 1));
        end
        m_dclk = dot;
        if (m_mode == 1) begin
          if (chg) begin m_mode = 2; m_busy = 1; m_to = 0; end
        end else begin
          m_to++;
          tout = (m_to >= TIMEOUT);
          if (dot || tout) begin
            m_mode = 0; m_tg = 0; m_sel = clamp_sel(s_in); m_div = d_in;
            if (m_rnum < 127) m_rnum++;
            if (tout && !dot) m_rflag = 1;
          end
        end
      end
      b_mem = SRC_EN[0] && (((b_n0 + 1) % 4) == 0);
      if (SRC_EN[0]) b_n0++;
    end
    last_sel = s_in;
    last_div = d_in;
  endtask

  task automatic check_all();
    chk("dclk_en",   a_dclk,  m_dclk);
    chk("tg_en",     a_tg,    m_tg);
    chk("busy",      a_busy,  m_busy);
    chk("phase",     a_phase, m_phase);
    chk("master_en", a_cme,   SRC_EN[m_sel]);
    chk("mem_req",   a_mem,   RAM_REQ);
    chk("resync",    a_rc,    exp_rc());
    chk("int_mem",   b_mem_o, b_mem);
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check_all();
  endtask

  // SRC_EN[0] every other cycle; upper sources random one-cycle pulses
  task automatic step_src(input logic [2:0] keep);
    logic [2:0] up;
    up     = 3'($urandom) & ~SRC_EN & 3'b110;
    SRC_EN = {up[2:1], (tgl % 2) == 0} & keep;
    tgl++;
  endtask

  task automatic run(input int n, input int ram_period);
    for (int k = 0; k < n; k++) begin
      step_src(3'b111);
      RAM_REQ = (ram_period > 0) && ((k % ram_period) == ram_period - 1);
      tick();
    end
    RAM_REQ = 1'b0;
  endtask

  initial begin
    int ens, last_dot, cnt64, g;
    bit first;
    logic [2:0] mask;

    RESET = 1'b1; SRC_EN = '0; SRC_SEL = '0; DIV = '0; RAM_REQ = 1'b0;
    repeat (3) tick();
    chk("rst_busy", a_busy, 1);
    chk("rst_tg", a_tg, 0);
    RESET = 1'b0;

    // Scenario: DIV=3 from source 0, slot at cycle 10
    DIV = 3'd3;
    tick();
    ens = 0; last_dot = -1; first = 1; tgl = 0;
    for (int k = 0; k < 80; k++) begin
      step_src(3'b111);
      RAM_REQ = (k == 10);
      tick();
      if (k == 10) chk("t1_tg_rise", a_tg, 1);
      if (k > 10 && SRC_EN[0]) ens++;
      if (a_dclk === 1'b1) begin
        if (first) chk("t1_first_dot_enables", ens, 4);
        else chk("t1_dot_period", k - last_dot, 8);
        first = 0; last_dot = k;
      end
    end
    RAM_REQ = 1'b0;

    // Scenario: DIV=1 running, then switch to DIV=3 mid-period
    DIV = 3'd1;
    run(40, 16);
    chk("t2_running", a_busy, 0);
    DIV = 3'd3;
    step_src(3'b111);
    tick();
    for (g = 0; g < 40; g++) begin
      step_src(3'b111);
      tick();
      if (a_dclk === 1'b1) break;
    end
    chk("t2_dot_seen", a_dclk, 1);
    chk("t2_dot_tg", a_tg, 0);
    chk("t2_dot_busy", a_busy, 1);
    run(40, 16);

    // Scenario: source 1 stalls during a switch to source 2 -> timeout exit
    SRC_SEL = '0; DIV = '0; SRC_EN = '0; RESET = 1'b1;
    repeat (2) tick();
    RESET = 1'b0;
    SRC_SEL = 2'd1; DIV = 3'd2;
    tick();
    RAM_REQ = 1'b1;
    tick();
    RAM_REQ = 1'b0;
    chk("t3_run", a_tg, 1);
    SRC_SEL = 2'd2;
    step_src(3'b101);
    tick();
    cnt64 = 0;
    for (g = 0; g < 200 && a_tg === 1'b1; g++) begin
      cnt64++;
      step_src(3'b101);
      tick();
    end
    chk("t3_drain_len", cnt64, 64);
`ifdef VDP_DOTCLK_RESYNC_CNT_EN
    chk("t3_resync", a_rc, 8'h81);
`else
    chk("t3_resync", a_rc, 8'h00);
`endif

    // Scenario: several DIV changes absorbed in DRAIN, newest wins
    SRC_EN = '0; RAM_REQ = 1'b1;
    tick();
    RAM_REQ = 1'b0;
    DIV = 3'd5; tick();
    chk("t4_drain", a_busy, 1);
    DIV = 3'd2; tick();
    DIV = 3'd7; tick();
    for (g = 0; g < 40 && a_tg === 1'b1; g++) begin
      SRC_EN = ((g % 2) == 0) ? 3'b100 : 3'b000;
      tick();
    end
    chk("t4_exited", a_tg, 0);
`ifdef VDP_DOTCLK_RESYNC_CNT_EN
    chk("t4_resync", a_rc, 8'h82);
`else
    chk("t4_resync", a_rc, 8'h00);
`endif
    SRC_EN = '0; RAM_REQ = 1'b1;
    tick();
    RAM_REQ = 1'b0;
    chk("t4_new_div", a_phase, 7);

    // Scenario: reset while draining
    DIV = 3'd6;
    tick();
    chk("t6_in_drain", a_busy, 1);
    RESET = 1'b1;
    tick();
    chk("t6_dclk", a_dclk, 0);
    chk("t6_tg", a_tg, 0);
    chk("t6_busy", a_busy, 1);
    chk("t6_phase", a_phase, 0);
    chk("t6_resync", a_rc, 0);
    RESET = 1'b0;

    // Scenario: change and slot strobe together keep waiting
    DIV = 3'd2; RAM_REQ = 1'b1;
    tick();
    chk("t5_change_wins_busy", a_busy, 1);
    chk("t5_change_wins_tg", a_tg, 0);
    tick();
    RAM_REQ = 1'b0;
    chk("t5_run_tg", a_tg, 1);
    chk("t5_run_phase", a_phase, 2);

    // Randomized traffic, with periodically stalled sources to provoke timeouts
    mask = 3'b111;
    for (int k = 0; k < 4000; k++) begin
      if ((k % 400) == 0) mask = 3'($urandom_range(1, 7));
      SRC_EN = 3'($urandom) & mask & ~SRC_EN;
      if ($urandom_range(0, 39) == 0) SRC_SEL = 2'($urandom);
      if ($urandom_range(0, 39) == 0) DIV = 3'($urandom);
      RAM_REQ = ($urandom_range(0, 11) == 0);
      RESET   = ($urandom_range(0, 999) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
